// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding req/ack imem port, 2-entry FIFO toward decode.
// Optional stall counter output enabled by defining FETCH_STALL_CNT_EN.
module fetch_stage #(
  parameter int                  PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                inp_clk,
  input  logic                inp_rst,
  output logic                out_imem_req,
  output logic [PC_WIDTH-1:0] out_imem_addr,
  input  logic                inp_imem_ack,
  input  logic [15:0]         inp_imem_data,
  output logic                out_valid,
  output logic [15:0]         out_instruction,
  output logic [PC_WIDTH-1:0] out_pc,
  input  logic                inp_stall,
  input  logic                inp_redirect,
  input  logic [PC_WIDTH-1:0] inp_redirect_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]         out_stall_cnt
`endif
);

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DROP} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PC_WIDTH-1:0] r_fetch_pc;
  logic [PC_WIDTH-1:0] w_fetch_pc_nxt;
  logic [PC_WIDTH-1:0] r_req_addr;
  logic [PC_WIDTH-1:0] w_req_addr_nxt;
  logic [1:0]          r_cnt;
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [15:0]         r_instr [2];
  logic [PC_WIDTH-1:0] r_pc    [2];

  logic                w_pop;
  logic                w_push;
  logic                w_flush;
  logic [1:0]          w_cnt_after_pop;
  logic [PC_WIDTH-1:0] w_pc_inc;

  assign w_pop           = (r_cnt != 2'd0) && !inp_stall;
  assign w_cnt_after_pop = r_cnt - {1'b0, w_pop};
  assign w_pc_inc        = r_fetch_pc + PC_ONE;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_addr_nxt = r_req_addr;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (inp_redirect) begin
          w_fetch_pc_nxt = inp_redirect_pc;
          w_flush        = 1'b1;
        end else if (w_cnt_after_pop < 2'd2) begin
          w_req_addr_nxt = r_fetch_pc;
          w_state_nxt    = S_BUSY;
        end
      end
      S_BUSY: begin
        if (inp_redirect) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = inp_redirect_pc;
          if (inp_imem_ack) w_req_addr_nxt = inp_redirect_pc;
          else              w_state_nxt    = S_DROP;
        end else if (inp_imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = w_pc_inc;
          // Only an empty-after-pop FIFO leaves room to issue the next word back-to-back.
          if (w_cnt_after_pop == 2'd0) w_req_addr_nxt = w_pc_inc;
          else                         w_state_nxt    = S_IDLE;
        end
      end
      S_DROP: begin
        if (inp_redirect) begin
          w_fetch_pc_nxt = inp_redirect_pc;
          w_flush        = 1'b1;
        end else if (inp_imem_ack) begin
          w_req_addr_nxt = r_fetch_pc;
          w_state_nxt    = S_BUSY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
    end
  end

  // FIFO control; a push never coincides with a flush.
  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst) begin
      r_cnt    <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else if (w_flush) begin
      r_cnt    <= 2'd0;
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge inp_clk) begin
    if (w_push) begin
      r_instr[r_wr_ptr] <= inp_imem_data;
      r_pc[r_wr_ptr]    <= r_req_addr;
    end
  end

  assign out_imem_req    = (r_state != S_IDLE);
  assign out_imem_addr   = r_req_addr;
  assign out_valid       = (r_cnt != 2'd0);
  assign out_instruction = out_valid ? r_instr[r_rd_ptr] : 16'h0000;
  assign out_pc          = out_valid ? r_pc[r_rd_ptr]    : '0;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge inp_clk or posedge inp_rst) begin
    if (inp_rst)
      r_stall_cnt <= 16'h0000;
    else if (out_valid && inp_stall && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'h0001;
  end

  assign out_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: queue-based reference model, directed scenarios, random traffic.
module tb_fetch_stage;

  logic        inp_clk = 1'b0;
  logic        inp_rst = 1'b0;
  logic        inp_imem_ack = 1'b0;
  logic [15:0] inp_imem_data = 16'h0000;
  logic        inp_stall = 1'b0;
  logic        inp_redirect = 1'b0;
  logic [15:0] inp_redirect_pc = 16'h0000;
  logic        out_imem_req;
  logic [15:0] out_imem_addr;
  logic        out_valid;
  logic [15:0] out_instruction;
  logic [15:0] out_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] out_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  fetch_stage #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .inp_clk         (inp_clk),
    .inp_rst         (inp_rst),
    .out_imem_req    (out_imem_req),
    .out_imem_addr   (out_imem_addr),
    .inp_imem_ack    (inp_imem_ack),
    .inp_imem_data   (inp_imem_data),
    .out_valid       (out_valid),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .inp_stall       (inp_stall),
    .inp_redirect    (inp_redirect),
    .inp_redirect_pc (inp_redirect_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .out_stall_cnt   (out_stall_cnt)
`endif
  );

  always #5 inp_clk = ~inp_clk;

  // Reference model: outstanding request flag, stale-response flag, queue of {instr, pc}.
  logic [15:0] m_pc   = 16'h0000;
  logic [15:0] m_addr = 16'h0000;
  bit          m_req  = 1'b0;
  bit          m_drop = 1'b0;
  logic [15:0] m_cnt  = 16'h0000;
  logic [31:0] q[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'h1000 + a;
  endfunction

  task automatic model_reset();
    m_pc   = 16'h0000;
    m_addr = 16'h0000;
    m_req  = 1'b0;
    m_drop = 1'b0;
    m_cnt  = 16'h0000;
    q.delete();
  endtask

  task automatic model_step(input bit a, input bit s, input bit r, input logic [15:0] rp);
    bit pop;
    pop = (q.size() > 0) && !s;
    if ((q.size() > 0) && s && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'h0001;
    if (r) begin
      q.delete();
      m_pc = rp;
      if (m_req && !m_drop) begin
        if (a) m_addr = rp;
        else   m_drop = 1'b1;
      end
    end else begin
      if (pop) void'(q.pop_front());
      if (!m_req) begin
        if (q.size() < 2) begin
          m_addr = m_pc;
          m_req  = 1'b1;
        end
      end else if (m_drop) begin
        if (a) begin
          m_addr = m_pc;
          m_drop = 1'b0;
        end
      end else if (a) begin
        q.push_back({mem_word(m_addr), m_addr});
        m_pc = m_pc + 16'h0001;
        if (q.size() < 2) m_addr = m_pc;
        else              m_req  = 1'b0;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge inp_clk) begin
    if (chk_en) begin
      chk("req",   {31'd0, out_imem_req}, {31'd0, m_req});
      chk("addr",  {16'd0, out_imem_addr}, {16'd0, m_addr});
      chk("valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      chk("instr", {16'd0, out_instruction}, (q.size() > 0) ? {16'd0, q[0][31:16]} : 32'd0);
      chk("pc",    {16'd0, out_pc}, (q.size() > 0) ? {16'd0, q[0][15:0]} : 32'd0);
`ifdef FETCH_STALL_CNT_EN
      chk("stall_cnt", {16'd0, out_stall_cnt}, {16'd0, m_cnt});
`endif
    end
  end

  task automatic step(input bit a, input bit s, input bit r, input logic [15:0] rp);
    inp_imem_ack    = a && out_imem_req;
    inp_imem_data   = inp_imem_ack ? (16'h1000 + out_imem_addr) : 16'hDEAD;
    inp_stall       = s;
    inp_redirect    = r;
    inp_redirect_pc = rp;
    @(posedge inp_clk);
    model_step(inp_imem_ack, s, r, rp);
    #1;
  endtask

  initial begin
    logic [15:0] c0;
    logic [15:0] rp;
    #1;
    inp_rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    #1;
    chk("rst_req",   {31'd0, out_imem_req}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) @(posedge inp_clk);
    #1 inp_rst = 1'b0;

    // Streaming with ack always high
    step(1, 0, 0, 16'h0);
    chk("t1_req",  {31'd0, out_imem_req}, 32'd1);
    chk("t1_addr", {16'd0, out_imem_addr}, 32'h0000);
    chk("t1_novalid", {31'd0, out_valid}, 32'd0);
    step(1, 0, 0, 16'h0);
    chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_instr0", {16'd0, out_instruction}, 32'h1000);
    chk("t1_pc0", {16'd0, out_pc}, 32'h0000);
    chk("t1_model_pc0", {16'd0, q[0][15:0]}, 32'h0000);
    step(1, 0, 0, 16'h0);
    chk("t1_pc1", {16'd0, out_pc}, 32'h0001);
    step(1, 0, 0, 16'h0);
    chk("t1_pc2", {16'd0, out_pc}, 32'h0002);
    step(1, 0, 0, 16'h0);
    chk("t1_pc3", {16'd0, out_pc}, 32'h0003);

    // Decode stalled for 6 cycles
    repeat (6) step(1, 1, 0, 16'h0);
    chk("t2_instr", {16'd0, out_instruction}, 32'h1003);
    chk("t2_pc", {16'd0, out_pc}, 32'h0003);
    chk("t2_req", {31'd0, out_imem_req}, 32'd0);
    step(1, 0, 0, 16'h0);
    chk("t2_pc4", {16'd0, out_pc}, 32'h0004);
    step(1, 0, 0, 16'h0);
    chk("t2_pc5", {16'd0, out_pc}, 32'h0005);

    // Redirect while waiting for a delayed ack
    step(0, 0, 0, 16'h0);
    chk("t3_addr_a", {16'd0, out_imem_addr}, 32'h0006);
    chk("t3_empty", {31'd0, out_valid}, 32'd0);
    step(0, 0, 1, 16'h0040);
    chk("t3_addr_b", {16'd0, out_imem_addr}, 32'h0006);
    chk("t3_req_b", {31'd0, out_imem_req}, 32'd1);
    step(0, 0, 0, 16'h0);
    chk("t3_addr_c", {16'd0, out_imem_addr}, 32'h0006);
    step(1, 0, 0, 16'h0);
    chk("t3_addr_new", {16'd0, out_imem_addr}, 32'h0040);
    chk("t3_dropped", {31'd0, out_valid}, 32'd0);
    step(1, 0, 0, 16'h0);
    chk("t3_pc", {16'd0, out_pc}, 32'h0040);
    chk("t3_instr", {16'd0, out_instruction}, 32'h1040);

    // Redirect coinciding with ack
    step(1, 0, 1, 16'h0100);
    chk("t4_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_addr", {16'd0, out_imem_addr}, 32'h0100);
    step(1, 0, 0, 16'h0);
    chk("t4_pc", {16'd0, out_pc}, 32'h0100);

    // Asynchronous reset mid-transaction with a stray ack
    inp_imem_ack  = 1'b1;
    inp_imem_data = 16'hBEEF;
    inp_rst       = 1'b1;
    model_reset();
    #1;
    chk("t5_req", {31'd0, out_imem_req}, 32'd0);
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_instr", {16'd0, out_instruction}, 32'd0);
    chk("t5_pc", {16'd0, out_pc}, 32'd0);
    chk("t5_addr", {16'd0, out_imem_addr}, 32'd0);
    repeat (2) @(posedge inp_clk);
    #1 inp_rst = 1'b0;
    step(1, 0, 0, 16'h0);
    chk("t5_restart_req", {31'd0, out_imem_req}, 32'd1);
    chk("t5_restart_addr", {16'd0, out_imem_addr}, 32'd0);
    step(1, 0, 0, 16'h0);
    chk("t5_restart_instr", {16'd0, out_instruction}, 32'h1000);

`ifdef FETCH_STALL_CNT_EN
    c0 = out_stall_cnt;
    repeat (10) step(1, 1, 0, 16'h0);
    chk("t6_stall_cnt", {16'd0, out_stall_cnt - c0}, 32'd10);
`else
    c0 = 16'h0000;
`endif

    // Random traffic including redirects near the top of the address space
    for (int i = 0; i < 3000; i++) begin
      rp = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
      step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0), rp);
    end

    @(negedge inp_clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
